// File: rtl/cache_master_arbiter.sv
// cache_master_arbiter: round-robin sharing of one AXI master bridge between the
// instruction cache (port 0) and the data cache (port 1).
module cache_master_arbiter #(
   parameter int DATA_W   = 32,
   parameter int TYPE_W   = 3,
   parameter int RD_BEATS = 4,
   parameter int WR_BEATS = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              s0_req,
   input  logic              s0_write,
   input  logic [TYPE_W-1:0] s0_wtype,
   input  logic [DATA_W-1:0] s0_wdata,
   input  logic [DATA_W-1:0] s0_addr,
   output logic              s0_wait,
   input  logic              s1_req,
   input  logic              s1_write,
   input  logic [TYPE_W-1:0] s1_wtype,
   input  logic [DATA_W-1:0] s1_wdata,
   input  logic [DATA_W-1:0] s1_addr,
   output logic              s1_wait,
   output logic [DATA_W-1:0] s_rdata,
   output logic              m_req,
   output logic              m_write,
   output logic [TYPE_W-1:0] m_wtype,
   output logic [DATA_W-1:0] m_wdata,
   output logic [DATA_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_wait
);
   localparam int MAXB = RD_BEATS > WR_BEATS ? RD_BEATS : WR_BEATS;
   localparam int CW   = $clog2(MAXB) + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, last_beat_q, last_beat_d;
   logic              grant_q, grant_d, last_grant_q, last_grant_d;
   logic              write_q, write_d;
   logic [TYPE_W-1:0] wtype_q, wtype_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, addr_q, addr_d;
   logic              win, win_write;

   // On a conflict the port that did not win last time gets the bridge
   assign win       = (s0_req && s1_req) ? ~last_grant_q : s1_req;
   assign win_write = win ? s1_write : s0_write;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_beat_d  = last_beat_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      write_d      = write_q;
      wtype_d      = wtype_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      if (state_q == IDLE) begin
         if (s0_req || s1_req) begin
            state_d     = BUSY;
            grant_d     = win;
            write_d     = win_write;
            wtype_d     = win ? s1_wtype : s0_wtype;
            wdata_d     = win ? s1_wdata : s0_wdata;
            addr_d      = win ? s1_addr : s0_addr;
            last_beat_d = win_write ? CW'(WR_BEATS - 1) : CW'(RD_BEATS - 1);
         end
      end else if (!m_wait) begin
         if (cnt_q == last_beat_q) begin
            cnt_d        = '0;
            state_d      = IDLE;
            last_grant_d = grant_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_beat_q  <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         write_q      <= 1'b0;
         wtype_q      <= '0;
         wdata_q      <= '0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_beat_q  <= last_beat_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         write_q      <= write_d;
         wtype_q      <= wtype_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
      end
   end

   assign m_req   = (state_q == BUSY);
   assign m_write = write_q;
   assign m_wtype = wtype_q;
   assign m_wdata = wdata_q;
   assign m_addr  = addr_q;
   assign s_rdata = m_rdata;
   // The port not holding the bridge simply sees its own request echoed as a stall
   assign s0_wait = (m_req && !grant_q) ? m_wait : s0_req;
   assign s1_wait = (m_req && grant_q) ? m_wait : s1_req;
endmodule

// File: tb/tb_cache_master_arbiter.sv
// tb_cache_master_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_cache_master_arbiter;
   localparam int RD = 4;
   localparam int WR = 1;

   logic        clk = 1'b0, rst = 1'b0;
   logic        s0_req = 0, s0_write = 0, s1_req = 0, s1_write = 0, m_wait = 1;
   logic [2:0]  s0_wtype = 0, s1_wtype = 0;
   logic [31:0] s0_wdata = 0, s0_addr = 0, s1_wdata = 0, s1_addr = 0, m_rdata = 0;
   logic        s0_wait, s1_wait, m_req, m_write;
   logic [2:0]  m_wtype;
   logic [31:0] s_rdata, m_wdata, m_addr;

   int errors = 0, checks = 0;

   bit          busy, gp, lg;
   int          left;
   logic        ew;
   logic [2:0]  ewt;
   logic [31:0] ewd, ea;

   logic        obs_req, obs_w0, obs_w1, obs_write;
   logic [31:0] obs_addr, obs_wdata;

   cache_master_arbiter #(.DATA_W(32), .TYPE_W(3), .RD_BEATS(RD), .WR_BEATS(WR)) dut (
      .clk(clk), .rst(rst),
      .s0_req(s0_req), .s0_write(s0_write), .s0_wtype(s0_wtype), .s0_wdata(s0_wdata),
      .s0_addr(s0_addr), .s0_wait(s0_wait),
      .s1_req(s1_req), .s1_write(s1_write), .s1_wtype(s1_wtype), .s1_wdata(s1_wdata),
      .s1_addr(s1_addr), .s1_wait(s1_wait),
      .s_rdata(s_rdata), .m_req(m_req), .m_write(m_write), .m_wtype(m_wtype),
      .m_wdata(m_wdata), .m_addr(m_addr), .m_rdata(m_rdata), .m_wait(m_wait)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic mreset();
      busy = 0; gp = 0; lg = 1; left = 0;
      ew = 0; ewt = 0; ewd = 0; ea = 0;
   endtask

   // One transaction at a time: who owns the bridge, how many beats remain, what was latched
   task automatic model_update();
      if (!rst) mreset();
      else if (!busy) begin
         if (s0_req || s1_req) begin
            gp   = (s0_req && s1_req) ? !lg : s1_req;
            ew   = gp ? s1_write : s0_write;
            ewt  = gp ? s1_wtype : s0_wtype;
            ewd  = gp ? s1_wdata : s0_wdata;
            ea   = gp ? s1_addr : s0_addr;
            left = ew ? WR : RD;
            busy = 1;
         end
      end else if (!m_wait) begin
         left--;
         if (left == 0) begin
            busy = 0;
            lg   = gp;
         end
      end
   endtask

   task automatic check_outs();
      chk("m_req", 32'(m_req), 32'(busy));
      chk("m_write", 32'(m_write), 32'(ew));
      chk("m_wtype", 32'(m_wtype), 32'(ewt));
      chk("m_wdata", m_wdata, ewd);
      chk("m_addr", m_addr, ea);
      chk("s0_wait", 32'(s0_wait), 32'((busy && !gp) ? m_wait : s0_req));
      chk("s1_wait", 32'(s1_wait), 32'((busy && gp) ? m_wait : s1_req));
      chk("s_rdata", s_rdata, m_rdata);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge
   task automatic step();
      m_rdata = $urandom;
      #1;
      check_outs();
      obs_req = m_req; obs_w0 = s0_wait; obs_w1 = s1_wait;
      obs_write = m_write; obs_addr = m_addr; obs_wdata = m_wdata;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_port(input bit p, input logic r, input logic w, input logic [2:0] wt,
                           input logic [31:0] wd, input logic [31:0] a);
      if (p) begin s1_req = r; s1_write = w; s1_wtype = wt; s1_wdata = wd; s1_addr = a; end
      else   begin s0_req = r; s0_write = w; s0_wtype = wt; s0_wdata = wd; s0_addr = a; end
   endtask

   task automatic txn(input string tag, input bit p, input logic w, input logic [2:0] wt,
                      input logic [31:0] wd, input logic [31:0] a, input logic [31:0] a2,
                      input bit drop);
      int beats = 0, first = -1, exp;
      bit seen = 0, done = 0;
      exp = w ? WR : RD;
      set_port(p, 1, w, wt, wd, a);
      for (int n = 0; n < 60 && !done; n++) begin
         m_wait = 1'($urandom_range(0, 1));
         step();
         if (obs_req) begin
            if (!seen) begin
               first = n;
               chk($sformatf("%s_write", tag), 32'(obs_write), 32'(w));
               chk($sformatf("%s_wdata", tag), obs_wdata, wd);
            end
            seen = 1;
            chk($sformatf("%s_addr", tag), obs_addr, a);
            if (!(p ? obs_w1 : obs_w0)) beats++;
            if (p) s1_addr = a2; else s0_addr = a2;
            if (drop || beats >= exp) begin
               if (p) s1_req = 0; else s0_req = 0;
            end
         end else if (seen) done = 1;
      end
      chk($sformatf("%s_lat", tag), 32'(first), 32'd1);
      chk($sformatf("%s_beats", tag), 32'(beats), 32'(exp));
      chk($sformatf("%s_done", tag), 32'(done), 32'd1);
      step();
      chk($sformatf("%s_idle", tag), 32'(obs_req), 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 0;
      mreset();
      step();
      rst = 1;
   endtask

   initial begin
      int beats, k, g[4];
      bit prev;
      mreset();
      @(negedge clk);
      step();
      chk("reset_mreq", 32'(obs_req), 32'd0);
      chk("reset_maddr", obs_addr, 32'd0);
      rst = 1;
      step();

      txn("im_rd", 0, 0, 3'b000, 32'h0, 32'h0000_1000, 32'h0000_1000, 0);
      txn("dm_wr", 1, 1, 3'b000, 32'hA5, 32'h0001_0004, 32'h0001_0004, 0);
      txn("stable", 0, 0, 3'b010, 32'h0, 32'h0000_1000, 32'h0000_2000, 0);
      txn("drop", 1, 0, 3'b000, 32'h0, 32'h0000_4000, 32'h0000_4000, 1);

      // Reset in the middle of a read burst
      set_port(0, 1, 0, 0, 0, 32'h3000);
      beats = 0;
      for (int n = 0; n < 40 && beats < 2; n++) begin
         m_wait = 1'($urandom_range(0, 1));
         step();
         if (obs_req && !obs_w0) beats++;
      end
      rst = 0;
      mreset();
      #1;
      chk("midrst_mreq", 32'(m_req), 32'd0);
      chk("midrst_s0wait", 32'(s0_wait), 32'd1);
      chk("midrst_maddr", m_addr, 32'd0);
      step();
      rst = 1;
      step();
      chk("rel_idle", 32'(obs_req), 32'd0);
      step();
      chk("rel_mreq", 32'(obs_req), 32'd1);
      s0_req = 0;
      for (int n = 0; n < 40 && obs_req; n++) begin
         m_wait = 1'($urandom_range(0, 1));
         step();
      end
      chk("rel_done", 32'(obs_req), 32'd0);

      // Both ports requesting continuously from reset: strict alternation starting with port 0
      pulse_reset();
      set_port(0, 1, 0, 0, 0, 32'h100);
      set_port(1, 1, 0, 0, 0, 32'h200);
      g = '{-1, -1, -1, -1};
      k = 0;
      prev = 0;
      for (int n = 0; n < 200 && k < 4; n++) begin
         m_wait = 1'($urandom_range(0, 1));
         step();
         if (obs_req && !prev) begin
            g[k] = (obs_addr == 32'h200) ? 1 : 0;
            k++;
         end
         prev = obs_req;
      end
      s0_req = 0; s1_req = 0;
      for (int n = 0; n < 40 && obs_req; n++) begin
         m_wait = 1'($urandom_range(0, 1));
         step();
      end
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(g[i]), 32'(i % 2));

      // Random traffic, including protocol-violating changes and rare async resets
      for (int n = 0; n < 600; n++) begin
         s0_req   = ($urandom_range(0, 3) != 0);
         s1_req   = ($urandom_range(0, 3) != 0);
         s0_write = 1'($urandom_range(0, 1));
         s1_write = 1'($urandom_range(0, 1));
         s0_wtype = 3'($urandom);
         s1_wtype = 3'($urandom);
         s0_wdata = $urandom; s1_wdata = $urandom;
         s0_addr  = $urandom; s1_addr  = $urandom;
         m_wait   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) begin
            rst = 0;
            mreset();
         end else rst = 1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
